// File: rtl/wb_cdb_arbiter.sv
// Writeback arbiter: three per-unit result FIFOs feeding one registered common data bus.
// Round-robin grant, valid/ready backpressure on both sides, synchronous flush.
module wb_cdb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [DATA_W-1:0] alu_value,
    input  logic [TAG_W-1:0]  alu_index,
    input  logic              mul_valid,
    output logic              mul_ready,
    input  logic [DATA_W-1:0] mul_value,
    input  logic [TAG_W-1:0]  mul_index,
    input  logic              div_valid,
    output logic              div_ready,
    input  logic [DATA_W-1:0] div_value,
    input  logic [TAG_W-1:0]  div_index,
    output logic              cdb_valid,
    input  logic              cdb_ready,
    output logic [DATA_W-1:0] cdb_value,
    output logic [TAG_W-1:0]  cdb_index,
    output logic [1:0]        cdb_src
);

    localparam int unsigned NSRC  = 3;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StIssue
    } sched_e;

    logic [NSRC-1:0]   src_valid;
    logic [NSRC-1:0]   src_ready;
    logic [NSRC-1:0]   push;
    logic [NSRC-1:0]   pop;
    logic [NSRC-1:0]   nonempty;
    logic [DATA_W-1:0] src_value [NSRC];
    logic [TAG_W-1:0]  src_index [NSRC];

    logic [DATA_W-1:0] mem_value [NSRC][DEPTH];
    logic [TAG_W-1:0]  mem_index [NSRC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q  [NSRC];
    logic [PTR_W-1:0]  rd_ptr_q  [NSRC];
    logic [CNT_W-1:0]  count_q   [NSRC];

    logic [1:0]        last_q;
    logic [1:0]        grant;
    logic [1:0]        cand [NSRC];
    logic              any_req;
    logic              load;
    sched_e            state;
    logic [DATA_W-1:0] head_value;
    logic [TAG_W-1:0]  head_index;

    assign src_valid    = {div_valid, mul_valid, alu_valid};
    assign src_value[0] = alu_value;
    assign src_value[1] = mul_value;
    assign src_value[2] = div_value;
    assign src_index[0] = alu_index;
    assign src_index[1] = mul_index;
    assign src_index[2] = div_index;
    assign alu_ready    = src_ready[0];
    assign mul_ready    = src_ready[1];
    assign div_ready    = src_ready[2];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // Ready looks only at the registered count, so a full FIFO stays
    // not-ready even in the cycle its head is popped.
    always_comb begin
        for (int k = 0; k < NSRC; k++) begin
            src_ready[k] = (count_q[k] < CNT_W'(DEPTH)) && !flush;
            push[k]      = src_valid[k] && src_ready[k];
            nonempty[k]  = (count_q[k] != '0);
        end
    end

    // Later assignments win, so cand[0] (the source after last) has top priority.
    always_comb begin
        cand[0] = next_src(last_q);
        cand[1] = next_src(cand[0]);
        cand[2] = next_src(cand[1]);
        any_req = |nonempty;
        grant   = last_q;
        if (nonempty[cand[2]]) grant = cand[2];
        if (nonempty[cand[1]]) grant = cand[1];
        if (nonempty[cand[0]]) grant = cand[0];
    end

    always_comb begin
        load  = !cdb_valid || cdb_ready;
        state = StIdle;
        if (!load) begin
            state = StHold;
        end else if (any_req) begin
            state = StIssue;
        end
    end

    always_comb begin
        for (int k = 0; k < NSRC; k++) begin
            pop[k] = (state == StIssue) && (grant == 2'(k)) && !flush;
        end
        head_value = mem_value[grant][rd_ptr_q[grant]];
        head_index = mem_index[grant][rd_ptr_q[grant]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSRC; k++) begin
                count_q[k]  <= '0;
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < NSRC; k++) begin
                count_q[k]  <= '0;
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSRC; k++) begin
                if (push[k]) wr_ptr_q[k] <= ptr_inc(wr_ptr_q[k]);
                if (pop[k])  rd_ptr_q[k] <= ptr_inc(rd_ptr_q[k]);
                case ({push[k], pop[k]})
                    2'b10:   count_q[k] <= count_q[k] + CNT_W'(1);
                    2'b01:   count_q[k] <= count_q[k] - CNT_W'(1);
                    default: count_q[k] <= count_q[k];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NSRC; k++) begin
            if (push[k]) begin
                mem_value[k][wr_ptr_q[k]] <= src_value[k];
                mem_index[k][wr_ptr_q[k]] <= src_index[k];
            end
        end
    end

    // Payload holds when the bus drains empty; only cdb_valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_value <= '0;
            cdb_index <= '0;
            cdb_src   <= 2'd0;
            last_q    <= 2'd2;
        end else if (flush) begin
            cdb_valid <= 1'b0;
            last_q    <= 2'd2;
        end else begin
            case (state)
                StIssue: begin
                    cdb_valid <= 1'b1;
                    cdb_value <= head_value;
                    cdb_index <= head_index;
                    cdb_src   <= grant;
                    last_q    <= grant;
                end
                StIdle:  cdb_valid <= 1'b0;
                default: cdb_valid <= cdb_valid;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// Directed and randomized bench for wb_cdb_arbiter against a queue-based
// transaction model of the arbiter.
module tb_wb_cdb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        cdb_ready = 1'b0;
    logic        in_valid [3];
    logic [31:0] in_value [3];
    logic [31:0] in_index [3];
    logic        alu_ready, mul_ready, div_ready;
    logic        dut_rdy [3];
    logic        cdb_valid;
    logic [31:0] cdb_value, cdb_index;
    logic [1:0]  cdb_src;

    assign dut_rdy[0] = alu_ready;
    assign dut_rdy[1] = mul_ready;
    assign dut_rdy[2] = div_ready;

    always #5 clk = ~clk;

    wb_cdb_arbiter #(.DATA_W(32), .TAG_W(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .alu_valid (in_valid[0]),
        .alu_ready (alu_ready),
        .alu_value (in_value[0]),
        .alu_index (in_index[0]),
        .mul_valid (in_valid[1]),
        .mul_ready (mul_ready),
        .mul_value (in_value[1]),
        .mul_index (in_index[1]),
        .div_valid (in_valid[2]),
        .div_ready (div_ready),
        .div_value (in_value[2]),
        .div_index (in_index[2]),
        .cdb_valid (cdb_valid),
        .cdb_ready (cdb_ready),
        .cdb_value (cdb_value),
        .cdb_index (cdb_index),
        .cdb_src   (cdb_src)
    );

    typedef struct packed {
        logic [31:0] value;
        logic [31:0] index;
    } entry_t;

    entry_t      mq [3][$];
    logic        m_valid;
    logic [31:0] m_value, m_index;
    int          m_src, m_last;
    int          n_checks = 0;
    int          n_errors = 0;
    int          gcount [3];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) mq[k].delete();
        m_valid = 1'b0;
        m_value = '0;
        m_index = '0;
        m_src   = 0;
        m_last  = 2;
    endtask

    // One clock edge of the arbiter, stated as queue operations.
    task automatic model_edge();
        bit     acc [3];
        int     g;
        entry_t e;
        if (flush) begin
            for (int k = 0; k < 3; k++) mq[k].delete();
            m_valid = 1'b0;
            m_last  = 2;
        end else begin
            for (int k = 0; k < 3; k++) acc[k] = in_valid[k] && (mq[k].size() < DEPTH);
            if (!m_valid || cdb_ready) begin
                g = -1;
                for (int i = 1; i <= 3; i++) begin
                    if (g < 0 && mq[(m_last + i) % 3].size() > 0) g = (m_last + i) % 3;
                end
                if (g >= 0) begin
                    e       = mq[g].pop_front();
                    m_valid = 1'b1;
                    m_value = e.value;
                    m_index = e.index;
                    m_src   = g;
                    m_last  = g;
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (acc[k]) mq[k].push_back({in_value[k], in_index[k]});
            end
        end
    endtask

    task automatic check_ready();
        check("alu_ready", 64'(alu_ready), 64'((mq[0].size() < DEPTH) && !flush));
        check("mul_ready", 64'(mul_ready), 64'((mq[1].size() < DEPTH) && !flush));
        check("div_ready", 64'(div_ready), 64'((mq[2].size() < DEPTH) && !flush));
    endtask

    task automatic check_bus();
        check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        check("cdb_value", 64'(cdb_value), 64'(m_value));
        check("cdb_index", 64'(cdb_index), 64'(m_index));
        check("cdb_src", 64'(cdb_src), 64'(m_src));
    endtask

    task automatic drive(input int k, input logic v, input logic [31:0] val,
                         input logic [31:0] idx);
        in_valid[k] = v;
        in_value[k] = val;
        in_index[k] = idx;
    endtask

    task automatic drive_rand(input logic [2:0] vmask);
        for (int k = 0; k < 3; k++) drive(k, vmask[k], $urandom, $urandom);
    endtask

    // Entered and left at posedge+1 (or later, before the next edge).
    task automatic cycle();
        #1;
        check_ready();
        @(posedge clk);
        model_edge();
        #1;
        check_bus();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        cdb_ready = 1'b0;
        drive_rand(3'b000);
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_ready();
        check_bus();
    endtask

    initial begin
        // Reset values, then single ALU result.
        do_reset();
        cdb_ready = 1'b1;
        drive(0, 1'b1, 32'h11, 32'd5);
        cycle();
        check("t1_lat_valid", 64'(cdb_valid), 64'd0);
        drive_rand(3'b000);
        cycle();
        check("t1_valid", 64'(cdb_valid), 64'd1);
        check("t1_value", 64'(cdb_value), 64'h11);
        check("t1_index", 64'(cdb_index), 64'd5);
        check("t1_src", 64'(cdb_src), 64'd0);
        cycle();
        check("t1_drain", 64'(cdb_valid), 64'd0);

        // Simultaneous pushes drain in ALU, MUL, DIV order.
        do_reset();
        cdb_ready = 1'b1;
        drive(0, 1'b1, 32'hA, 32'd1);
        drive(1, 1'b1, 32'hB, 32'd2);
        drive(2, 1'b1, 32'hC, 32'd3);
        cycle();
        drive_rand(3'b000);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t2_src", 64'(cdb_src), 64'(i));
            check("t2_value", 64'(cdb_value), 64'(32'hA + i));
        end

        // Fairness under continuous traffic.
        do_reset();
        cdb_ready = 1'b1;
        for (int k = 0; k < 3; k++) gcount[k] = 0;
        drive_rand(3'b111);
        cycle();
        for (int i = 0; i < 9; i++) begin
            drive_rand(3'b111);
            cycle();
            if (cdb_valid) gcount[cdb_src]++;
        end
        for (int k = 0; k < 3; k++) check("t3_grants", 64'(gcount[k]), 64'd3);

        // Backpressure with MUL result held on the bus.
        do_reset();
        cdb_ready = 1'b1;
        drive(1, 1'b1, 32'h22, 32'd7);
        cycle();
        drive_rand(3'b000);
        cdb_ready = 1'b0;
        cycle();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(0, 1'b1, 32'(i + 1), 32'(i + 40));
            else drive_rand(3'b000);
            if (i == 2) check("t4_alu_full", 64'(alu_ready), 64'd0);
            cycle();
            check("t4_hold_value", 64'(cdb_value), 64'h22);
            check("t4_hold_index", 64'(cdb_index), 64'd7);
            check("t4_hold_src", 64'(cdb_src), 64'd1);
        end
        cdb_ready = 1'b1;
        cycle();
        check("t4_resume1", 64'(cdb_value), 64'h1);
        cycle();
        check("t4_resume2", 64'(cdb_value), 64'h2);

        // Flush with full FIFOs and a held bus result.
        do_reset();
        cdb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rand(3'b111);
            cycle();
        end
        check("t5_pre_valid", 64'(cdb_valid), 64'd1);
        flush = 1'b1;
        drive_rand(3'b111);
        cycle();
        check("t5_post_valid", 64'(cdb_valid), 64'd0);
        flush = 1'b0;
        cdb_ready = 1'b1;
        drive_rand(3'b111);
        cycle();
        drive_rand(3'b000);
        cycle();
        check("t5_first_src", 64'(cdb_src), 64'd0);
        cycle();

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            drive_rand(3'($urandom));
            cdb_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush = 1'b0;

        // Asynchronous reset mid-stream.
        cdb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand(3'b111);
            cycle();
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t6_valid", 64'(cdb_valid), 64'd0);
        check("t6_value", 64'(cdb_value), 64'd0);
        check("t6_index", 64'(cdb_index), 64'd0);
        check("t6_src", 64'(cdb_src), 64'd0);
        check_ready();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_rand(3'($urandom));
            cdb_ready = $urandom_range(0, 1) != 0;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
